// File: rtl/sort_pkg.sv
// Shared definitions for the top-K sorter read side.
// Holds list depth and widths, the FIFO payload struct and the drain FSM states.
package sort_pkg;

  localparam int unsigned K  = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = $clog2(K + 1);

  typedef struct packed {
    logic [DW-1:0] value;
    logic [IW-1:0] index;
    logic          last;
  } topk_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_CLEAR
  } drain_state_e;

endpackage

// File: rtl/skid_fifo.sv
// Synchronous FIFO of sorter entries that absorbs downstream back-pressure.
// Ports: clk, rst (async active-low), i_push/i_data write side,
// i_pop/o_data read side (o_data is the head entry), o_full, o_empty,
// o_free_cnt (number of unused slots).
module skid_fifo
  import sort_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FCW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  topk_entry_t     i_data,
  input  logic            i_pop,
  output topk_entry_t     o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [FCW-1:0]  o_free_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  topk_entry_t    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [FCW-1:0] r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_full     = (r_cnt == FCW'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_free_cnt = FCW'(DEPTH) - r_cnt;
  assign o_data     = r_mem[r_rd_ptr];

  // Guard against misuse; a push into a full FIFO is allowed only alongside a pop.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + FCW'(w_push) - FCW'(w_pop);
    end
  end

endmodule

// File: rtl/topk_drain.sv
// Read-side controller for the top-K sorter: issues exactly K reads per drain,
// forwards the first min(count,K) entries as a valid/ready stream with last,
// then clears the sorter.
// Ports: clk, rst (async active-low); start/count request, busy/done status;
// srt_rd/srt_value/srt_index/srt_clear sorter side;
// m_valid/m_ready/m_value/m_index/m_last output stream.
module topk_drain
  import sort_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          srt_rd,
  input  logic [DW-1:0] srt_value,
  input  logic [IW-1:0] srt_index,
  output logic          srt_clear,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_value,
  output logic [IW-1:0] m_index,
  output logic          m_last
);

  localparam int unsigned FCW = $clog2(FD + 1);
  localparam int unsigned FW  = FCW + 1;

  drain_state_e   r_state;
  drain_state_e   w_state_nxt;
  logic           r_busy;
  logic           r_done;
  logic           r_srt_rd;
  logic           r_srt_clear;
  logic           r_cap;
  logic [CW-1:0]  r_cnt_eff;
  logic [CW-1:0]  r_rd_cnt;
  logic [CW-1:0]  r_cap_cnt;
  logic           w_accept;
  logic           w_rd_nxt;
  logic           w_push;
  logic           w_pop;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [FCW-1:0] w_free;
  logic [FW-1:0]  w_free_nxt;
  logic           w_drained;
  topk_entry_t    w_push_data;
  topk_entry_t    w_head;

  // Capture cycle is the registered read strobe; only the first cnt_eff entries are kept.
  assign w_push            = r_cap && (r_cap_cnt < r_cnt_eff);
  assign w_push_data.value = srt_value;
  assign w_push_data.index = srt_index;
  assign w_push_data.last  = (r_cap_cnt == r_cnt_eff - CW'(1));
  assign w_pop             = m_valid && m_ready;

  // Free slots after this cycle's push/pop; pop is included so reads resume right after a pop.
  assign w_free_nxt = FW'(w_free) - FW'(w_push) + FW'(w_pop);
  assign w_drained  = (w_free_nxt == FW'(FD));

  skid_fifo #(.DEPTH(FD)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (w_push_data),
    .i_pop      (w_pop),
    .o_data     (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_free_cnt (w_free)
  );

  // Drain FSM next-state and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_rd_nxt    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_rd_cnt < CW'(K)) begin
          // Reserve a slot for the read already in flight plus the new one.
          w_rd_nxt = !w_fifo_full && (w_free_nxt > FW'(r_srt_rd));
        end else if (!r_srt_rd) begin
          // Skip FLUSH when the discarded tail leaves nothing to forward.
          w_state_nxt = w_drained ? S_CLEAR : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_drained) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Registered status, strobes and drain counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_srt_rd    <= 1'b0;
      r_srt_clear <= 1'b0;
      r_cap       <= 1'b0;
      r_cnt_eff   <= '0;
      r_rd_cnt    <= '0;
      r_cap_cnt   <= '0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_CLEAR);
      r_srt_clear <= (w_state_nxt == S_CLEAR);
      r_srt_rd    <= w_rd_nxt;
      r_cap       <= r_srt_rd;
      if (w_accept) begin
        r_cnt_eff <= (count > CW'(K)) ? CW'(K) : count;
        r_rd_cnt  <= CW'(1);
        r_cap_cnt <= '0;
      end else begin
        if (w_rd_nxt) r_rd_cnt  <= r_rd_cnt + CW'(1);
        if (r_cap)    r_cap_cnt <= r_cap_cnt + CW'(1);
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign srt_rd    = r_srt_rd;
  assign srt_clear = r_srt_clear;
  assign m_valid   = !w_fifo_empty;
  assign m_value   = w_head.value;
  assign m_index   = w_head.index;
  assign m_last    = w_head.last;

endmodule
